// File: rtl/fifo_read_ctrl_if.sv
// rtl/fifo_read_ctrl_if.sv - read-side FIFO controller bundle: memory read port, output stream, pointers.
interface fifo_read_ctrl_if #(
  parameter int adr_width  = 3,
  parameter int data_width = 8
);
  logic [adr_width:0]    write_adr_gray_sync;
  logic                  mem_read_en;
  logic [adr_width-1:0]  mem_read_adr;
  logic [data_width-1:0] mem_read_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic [adr_width:0]    read_adr_gray;
  logic                  FIFO_empty;

  modport master (
    input  write_adr_gray_sync,
    input  mem_read_data,
    input  out_ready,
    output mem_read_en,
    output mem_read_adr,
    output out_valid,
    output out_data,
    output read_adr_gray,
    output FIFO_empty
  );

  modport slave (
    output write_adr_gray_sync,
    output mem_read_data,
    output out_ready,
    input  mem_read_en,
    input  mem_read_adr,
    input  out_valid,
    input  out_data,
    input  read_adr_gray,
    input  FIFO_empty
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - async FIFO read-side controller with first-word fall-through two-entry output buffer.
module fifo_read_ctrl #(
  parameter int depth      = 8,
  parameter int adr_width  = $clog2(depth),
  parameter int data_width = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_read_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  logic [adr_width:0]    r_rd_bin;
  logic [adr_width:0]    r_rd_gray;
  logic [data_width-1:0] r_main;
  logic [data_width-1:0] r_skid;
  logic                  r_inflight;

  logic                  w_empty;
  logic                  w_pop;
  logic                  w_issue;
  logic [1:0]            w_count;
  logic [1:0]            w_occ_after_pop;
  logic [adr_width:0]    w_rd_bin_next;
  logic [adr_width:0]    w_rd_gray_next;

  assign w_count = r_state;
  assign w_empty = (r_rd_gray == bus.write_adr_gray_sync);
  assign w_pop   = (r_state != S_EMPTY) & bus.out_ready;

  // Counting the in-flight word as occupied keeps the two-entry buffer from overflowing.
  assign w_occ_after_pop = w_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue         = !rst & !w_empty & (w_occ_after_pop < 2'd2);

  assign w_rd_bin_next  = r_rd_bin + 1'b1;
  assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);

  assign bus.mem_read_en   = w_issue;
  assign bus.mem_read_adr  = r_rd_bin[adr_width-1:0];
  assign bus.out_valid     = (r_state != S_EMPTY);
  assign bus.out_data      = r_main;
  assign bus.read_adr_gray = r_rd_gray;
  assign bus.FIFO_empty    = w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_rd_bin   <= '0;
      r_rd_gray  <= '0;
      r_main     <= '0;
      r_skid     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_bin  <= w_rd_bin_next;
        r_rd_gray <= w_rd_gray_next;
      end
      // Returning data lands in the first slot left free once this cycle's pop is applied.
      case (r_state)
        S_EMPTY: begin
          if (r_inflight) begin
            r_main  <= bus.mem_read_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_pop) begin
            if (r_inflight) begin
              r_main <= bus.mem_read_data;
            end else begin
              r_state <= S_EMPTY;
            end
          end else if (r_inflight) begin
            r_skid  <= bus.mem_read_data;
            r_state <= S_TWO;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_main <= r_skid;
            if (r_inflight) begin
              r_skid <= bus.mem_read_data;
            end else begin
              r_state <= S_ONE;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - randomized self-checking bench for fifo_read_ctrl against a word-count reference model.
module tb_fifo_read_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DW    = 8;
  localparam int PMOD  = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_read_ctrl_if #(.adr_width(AW), .data_width(DW)) bus ();

  fifo_read_ctrl #(.depth(DEPTH), .adr_width(AW), .data_width(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_read_en) bus.mem_read_data <= mem[bus.mem_read_adr];
  end

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_rd     = 0;
  int            n_acc    = 0;
  int            wr_tot   = 0;
  int            wr_vis   = 0;
  bit            m_inflight = 1'b0;
  bit            mon_en   = 1'b0;
  logic [DW-1:0] exp_q [$];
  int            cyc      = 0;
  int            first_acc_cyc = -1;
  int            last_acc_cyc  = -1;
  int            issue_cnt = 0;
  int            wrap_cnt  = 0;
  bit            have_prev = 1'b0;
  logic [AW-1:0] prev_adr  = '0;

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  // Reference model: words read but not yet accepted are either buffered or the one in flight.
  always @(negedge clk) begin : monitor
    int            buffered;
    bit            e_valid;
    bit            e_pop;
    bit            e_empty;
    bit            e_en;
    logic [AW-1:0] e_adr;
    if (mon_en && !rst) begin
      buffered = n_rd - n_acc - (m_inflight ? 1 : 0);
      e_valid  = buffered > 0;
      e_pop    = e_valid && (bus.out_ready === 1'b1);
      e_empty  = (n_rd % PMOD) == (wr_vis % PMOD);
      e_en     = !e_empty && ((n_rd - n_acc - (e_pop ? 1 : 0)) < 2);
      e_adr    = AW'(n_rd % DEPTH);

      n_checks++;
      if (bus.out_valid !== e_valid) begin
        n_fail++;
        $display("FAIL mon_out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, e_valid);
      end
      n_checks++;
      if (bus.FIFO_empty !== e_empty) begin
        n_fail++;
        $display("FAIL mon_fifo_empty cyc=%0d got=%b exp=%b", cyc, bus.FIFO_empty, e_empty);
      end
      n_checks++;
      if (bus.mem_read_en !== e_en) begin
        n_fail++;
        $display("FAIL mon_mem_read_en cyc=%0d got=%b exp=%b", cyc, bus.mem_read_en, e_en);
      end
      n_checks++;
      if (bus.read_adr_gray !== gray(n_rd)) begin
        n_fail++;
        $display("FAIL mon_read_adr_gray cyc=%0d got=%b exp=%b", cyc, bus.read_adr_gray, gray(n_rd));
      end
      if (e_en) begin
        n_checks++;
        if (bus.mem_read_adr !== e_adr) begin
          n_fail++;
          $display("FAIL mon_mem_read_adr cyc=%0d got=%0d exp=%0d", cyc, bus.mem_read_adr, e_adr);
        end
      end
      if (e_pop) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon_out_data cyc=%0d got=%h exp=<none>", cyc, bus.out_data);
        end else begin
          if (bus.out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL mon_out_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_acc++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (e_en) begin
        if (have_prev && prev_adr == AW'(DEPTH - 1) && e_adr == '0) wrap_cnt++;
        prev_adr  = e_adr;
        have_prev = 1'b1;
        n_rd++;
        issue_cnt++;
      end
      m_inflight = e_en;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    n_rd = 0; n_acc = 0; wr_tot = 0; wr_vis = 0;
    m_inflight = 1'b0;
    exp_q.delete();
    first_acc_cyc = -1; last_acc_cyc = -1;
    issue_cnt = 0; wrap_cnt = 0; have_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    bus.out_ready = 1'($urandom);
    bus.write_adr_gray_sync = PW'($urandom);
    tick();
    tick();
    clear_model();
    bus.write_adr_gray_sync = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_tot % DEPTH] = d;
    exp_q.push_back(d);
    wr_tot++;
  endtask

  task automatic publish();
    wr_vis = wr_tot;
    bus.write_adr_gray_sync = gray(wr_vis);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    bus.out_ready = 1'b1;
    bus.write_adr_gray_sync = PW'($urandom_range(1, PMOD - 1));
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.mem_read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem_read_en_during got=%b exp=0", bus.mem_read_en);
    end
    tick();
    clear_model();
    bus.write_adr_gray_sync = '0;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.read_adr_gray !== '0) begin n_fail++; $display("FAIL reset_read_adr_gray got=%b exp=0", bus.read_adr_gray); end
    n_checks++;
    if (bus.FIFO_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_empty got=%b exp=1", bus.FIFO_empty); end
    n_checks++;
    if (bus.mem_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read_en got=%b exp=0", bus.mem_read_en); end
  endtask

  task automatic test_single_word();
    tick();
    push(8'hA5);
    publish();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_read_en !== 1'b1 || bus.mem_read_adr !== '0) begin
      n_fail++;
      $display("FAIL single_issue got=en%b/adr%0d exp=en1/adr0", bus.mem_read_en, bus.mem_read_adr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_c1 got=%b exp=0", bus.out_valid); end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_out_c2 got=v%b/%h exp=v1/a5", bus.out_valid, bus.out_data);
    end
    n_checks++;
    if (bus.FIFO_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got=%b exp=1", bus.FIFO_empty); end
    n_checks++;
    if (bus.read_adr_gray !== 4'b0001) begin n_fail++; $display("FAIL single_gray got=%b exp=0001", bus.read_adr_gray); end
    tick();
    tick();
  endtask

  task automatic test_streaming();
    int c0;
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(i));
    publish();
    bus.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 40 && n_acc < 8; i++) tick();
    n_checks++;
    if (n_acc !== 8) begin n_fail++; $display("FAIL stream_count got=%0d exp=8", n_acc); end
    n_checks++;
    if (first_acc_cyc - c0 !== 2) begin n_fail++; $display("FAIL stream_latency got=%0d exp=2", first_acc_cyc - c0); end
    n_checks++;
    if (last_acc_cyc - first_acc_cyc !== 7) begin
      n_fail++;
      $display("FAIL stream_throughput got=%0d exp=7", last_acc_cyc - first_acc_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (bus.read_adr_gray !== 4'b1100) begin n_fail++; $display("FAIL stream_gray got=%b exp=1100", bus.read_adr_gray); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    logic [DW-1:0] w0;
    bit            held_valid;
    do_reset();
    w0 = DW'($urandom);
    push(w0);
    for (int i = 1; i < 5; i++) push(DW'($urandom));
    publish();
    bus.out_ready = 1'b0;
    issue_cnt = 0;
    held_valid = 1'b0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        if (held_valid) begin
          n_checks++;
          if (bus.out_data !== held) begin n_fail++; $display("FAIL bp_stable got=%h exp=%h", bus.out_data, held); end
        end else begin
          held = bus.out_data;
          held_valid = 1'b1;
        end
      end
      tick();
    end
    n_checks++;
    if (issue_cnt !== 2) begin n_fail++; $display("FAIL bp_reads_in_stall got=%0d exp=2", issue_cnt); end
    n_checks++;
    if (!held_valid || held !== w0) begin n_fail++; $display("FAIL bp_head got=v%b/%h exp=v1/%h", held_valid, held, w0); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && n_acc < 5; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (n_acc !== 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_delivered got=%0d left=%0d exp=5 left=0", n_acc, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 800 && n_acc < 20; i++) begin
      bus.out_ready = ($urandom % 4) != 0;
      if (wr_tot < 20 && (wr_tot - n_acc) < DEPTH && ($urandom % 4) != 0) push(DW'($urandom));
      if (($urandom % 2) != 0 || wr_tot == 20) publish();
      tick();
    end
    n_checks++;
    if (n_acc !== 20 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_delivered got=%0d left=%0d exp=20 left=0", n_acc, exp_q.size());
    end
    n_checks++;
    if (wrap_cnt !== 2) begin n_fail++; $display("FAIL wrap_adr_wraps got=%0d exp=2", wrap_cnt); end
    @(negedge clk);
    n_checks++;
    if (bus.read_adr_gray !== 4'b0110) begin n_fail++; $display("FAIL wrap_gray got=%b exp=0110", bus.read_adr_gray); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h40 + i));
    publish();
    bus.out_ready = 1'b0;
    tick();
    tick();
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_read_en !== 1'b1 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup got=en%b/v%b exp=en1/v1", bus.mem_read_en, bus.out_valid);
    end
    tick();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre got=v%b/en%b exp=v1/en0", bus.out_valid, bus.mem_read_en);
    end
    tick();
    clear_model();
    bus.write_adr_gray_sync = '0;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
        n_fail++;
        $display("FAIL midrst_out k=%0d got=v%b/%h exp=v0/00", k, bus.out_valid, bus.out_data);
      end
      n_checks++;
      if (bus.read_adr_gray !== '0 || bus.mem_read_adr !== '0) begin
        n_fail++;
        $display("FAIL midrst_ptr k=%0d got=%b/%0d exp=0/0", k, bus.read_adr_gray, bus.mem_read_adr);
      end
      tick();
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.write_adr_gray_sync = '0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the asynchronous FIFO. It owns the read pointer, drives the synchronous memory read port, and presents the stored words on a valid/ready stream with first-word fall-through and full throughput. It runs entirely in the read clock domain. Its inputs are the write pointer, already Gray-coded and synchronized into this domain, and the memory read data. Its outputs are the Gray read pointer for the write-side synchronizer and the FIFO empty status.

## Interface
- `depth`, 8: FIFO entries; power of two, ≥ 2.
- `adr_width`, `$clog2(depth)`: memory address width; pointers carry one extra wrap bit.
- `data_width`, 8: word width.

- `clk`  in  1  read-domain clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `write_adr_gray_sync`  in  adr_width+1  write pointer, Gray-coded, already synchronized.
- `mem_read_en`  out  1  memory read strobe; data returns one cycle later.
- `mem_read_adr`  out  adr_width  memory read address, equal to the low bits of the binary read pointer.
- `mem_read_data`  in  data_width  memory data, valid the cycle after `mem_read_en`.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  data_width  head word.
- `read_adr_gray`  out  adr_width+1  registered Gray read pointer, sent to the write side.
- `FIFO_empty`  out  1  no unread words remain in memory.

## Operation
- **Pointers**
  - `rd_bin` is adr_width+1 bits, wraps modulo 2·depth, and increments by 1 on every issued read.
  - `read_adr_gray` is the registered value of `rd_bin ^ (rd_bin >> 1)` and updates in the same cycle as `rd_bin`.
- **Empty**
  - `FIFO_empty = (read_adr_gray == write_adr_gray_sync)`, combinational from registers and inputs.
  - It covers memory only. Words already fetched into the output buffer do not count.
- **Output buffer**
  - Two entries, main and skid, in FIFO order.
  - `out_data` always shows the main entry.
  - `out_valid` is high whenever the main entry is occupied.
- **In-flight flag** (`inflight`): a read was issued in the previous cycle.
- **Issue rule**
  - `pop = out_valid & out_ready`.
  - `occ = buffered entries + inflight`.
  - `mem_read_en = !FIFO_empty & (occ - pop < 2)`.
  - The buffer can therefore never overflow.
- **Returning data** (when `inflight` is set)
  - Written into the first free buffer slot after this cycle's pop is applied.
  - If the buffer is empty, or the main entry is popping with no skid entry, the data goes straight to main.
- **Pop**
  - The skid entry, if present, shifts into main.
  - The order of words out always equals memory order.
- **Controller states**, derived from the buffer count:
  - EMPTY: 0 buffered.
  - ONE: 1 buffered.
  - TWO: 2 buffered.
  - `inflight` is orthogonal to these states.
- **Wrap**: the pointer wraps from 2·depth−1 to 0. `mem_read_adr` wraps from depth−1 to 0 with no bubble.
- **Full throughput**: with memory non-empty and `out_ready` held high, one word is accepted every cycle after the initial fill latency.
- **Stale write pointer**: the synchronized write pointer may lag, so `FIFO_empty` may read high while words exist. The block only waits and never reads past the pointer.

## Timing
- **Reset values** (when `rst` is high at a clock edge, overriding all other activity, including mid-transfer):
  - `rd_bin` = 0, `read_adr_gray` = 0.
  - Buffer cleared, `inflight` = 0.
  - `out_valid` = 0, `out_data` = 0.
  - `mem_read_en` = 0 during reset.
  - A read in flight at reset is discarded.
  - `FIFO_empty` = 1 while `write_adr_gray_sync` is also 0.
- **Fill latency**: from a cycle N where `FIFO_empty` drops with the buffer idle:
  - `mem_read_en` is high in cycle N.
  - `out_valid` goes high in cycle N+2.
- **Handshake**
  - `out_data` is stable while `out_valid & !out_ready`.
  - `out_valid` never drops without a pop, except by reset.
- **Pointer timing**: `read_adr_gray` changes exactly one cycle after each `mem_read_en`, one bit per increment.
- **Simultaneous pop, data return and issue**: all three in one cycle are legal. The buffer count changes by (return − pop).

## Test plan
- **Reset**: assert `rst` with arbitrary inputs, then release.
  - Required: `out_valid` = 0, `read_adr_gray` = 0, `FIFO_empty` = 1, `mem_read_en` = 0.
- **Single word**: set `write_adr_gray_sync` = 1 (Gray 0001) at cycle 0, `out_ready` = 1.
  - Required: `mem_read_en` with address 0 at cycle 0.
  - Required: `out_valid` with the memory word at cycle 2, then `FIFO_empty` = 1 and `read_adr_gray` = 0001.
- **Streaming**: 8 words available, `out_ready` = 1.
  - Required: 8 consecutive accepts, data 0x00–0x07 in order.
  - Required: final `read_adr_gray` = Gray(8) = 01100.
- **Backpressure**: 5 words available, `out_ready` = 0 for 6 cycles, then 1.
  - Required: exactly 2 reads issued during the stall, `out_data` stable.
  - Required: all 5 words delivered in order after release, with no drop or duplicate.
- **Wrap**: stream 20 words with a write pointer advancing in Gray.
  - Required: `mem_read_adr` sequence 7→0 with no gap.
  - Required: pointer wraps from 15 to 0, `read_adr_gray` matches the golden Gray sequence.
- **Mid-transfer reset**: assert `rst` one cycle after a read issue with 2 words buffered.
  - Required: the next cycle shows `out_valid` = 0, no capture of the returning word, and pointers at 0.
